// File: rtl/mem_access_pkg.sv
// Shared definitions for the byte-serial load/store initiator: size encodings,
// FSM state type and size decoding helpers.
package mem_access_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic [2:0] byte_count(input logic [2:0] size);
    case (size)
      SZ_H, SZ_HU: return 3'd2;
      SZ_W:        return 3'd4;
      default:     return 3'd1;
    endcase
  endfunction

  // Encodings that never map to a transfer, plus unsigned sizes on stores.
  function automatic logic size_illegal(input logic [2:0] size, input logic write);
    case (size)
      SZ_B, SZ_H, SZ_W: return 1'b0;
      SZ_BU, SZ_HU:     return write;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Combinational sign/zero extension of the assembled load bytes by access size.
module mem_load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] asm_data,
  output logic [31:0] ext_data
);

  always_comb begin
    ext_data = asm_data;
    case (size)
      SZ_B:    ext_data = {{24{asm_data[7]}}, asm_data[7:0]};
      SZ_H:    ext_data = {{16{asm_data[15]}}, asm_data[15:0]};
      SZ_BU:   ext_data = {24'd0, asm_data[7:0]};
      SZ_HU:   ext_data = {16'd0, asm_data[15:0]};
      default: ext_data = asm_data;
    endcase
  end

endmodule

// File: rtl/mem_access_master.sv
// Byte-serial load/store initiator for an 8-bit data memory port.
// Optional MEM_ACCESS_ALIGN_CHECK_EN rejects misaligned halfword/word requests.
module mem_access_master
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic [1:0]            dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE. Responses are a
  // single-cycle resp_valid pulse with no backpressure.

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [31:0]             asm_q, asm_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [31:0]             ext_data;
  logic                    misalign;
  logic                    last_byte;

  mem_load_extend u_extend (
    .size     (size_q),
    .asm_data (asm_q),
    .ext_data (ext_data)
  );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = (((req_size == SZ_H) || (req_size == SZ_HU)) && req_addr[0]) ||
                    ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign last_byte = ({1'b0, idx_q} == (byte_count(size_q) - 3'd1));
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = rdata_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          idx_d   = 2'd0;
          asm_d   = '0;
          state_d = (size_illegal(req_size, req_write) || misalign) ? ST_ERR : ST_XFER;
        end
      end
      ST_XFER: begin
        mem_en    = 1'b1;
        mem_we    = write_q;
        mem_addr  = addr_q + ADDR_WIDTH'(idx_q);
        mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        if (!write_q) asm_d[{idx_q, 3'b000} +: 8] = mem_rdata;
        if (last_byte) begin
          idx_d   = 2'd0;
          state_d = ST_RESP;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = write_q ? '0 : DATA_WIDTH'(ext_data);
        rdata_d    = resp_rdata;
        state_d    = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        resp_rdata = '0;
        rdata_d    = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: directed vector table, reset and
// back-to-back sequences, and randomized requests against a byte-array model.
module tb_mem_access_master;

  localparam int DW = 32;
  localparam int AW = 17;
  localparam int MEM_BYTES = 1 << AW;
  localparam logic [AW-1:0] AMASK = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [2:0]    req_size = 3'd0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  // Memory seen by the DUT, and the reference contents the model expects.
  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];

  mem_access_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] v);
    mem[a] <= v;
    ref_mem[a] = v;
  endtask

  // ---------------- reference model ----------------
  function automatic int model_nbytes(input logic [2:0] sz);
    if (sz == 3'b010) return 4;
    if (sz == 3'b001 || sz == 3'b101) return 2;
    return 1;
  endfunction

  function automatic logic model_err(input logic w, input logic [2:0] sz, input logic [AW-1:0] a);
    logic bad;
    bad = (sz == 3'b011) || (sz == 3'b110) || (sz == 3'b111) ||
          (w && (sz == 3'b100 || sz == 3'b101));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((sz == 3'b001 || sz == 3'b101) && (a % 2 != 0)) bad = 1'b1;
    if (sz == 3'b010 && (a % 4 != 0)) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [AW-1:0] a);
    longint v;
    int n;
    n = model_nbytes(sz);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (longint'(ref_mem[(a + AW'(i)) & AMASK]) << (8 * i));
    if ((sz == 3'b000 || sz == 3'b001) && v >= (64'sd1 << (8 * n - 1)))
      v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- driver: one full request/response ----------------
  task automatic do_txn(input logic w, input logic [2:0] sz, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input string tag);
    int n;
    logic [AW-1:0] ea;
    n = model_nbytes(sz);
    @(negedge clk);
    req_write = w; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        ea = (a + AW'(i)) & AMASK;
        check({tag, ".mem_en"}, 32'(mem_en), 32'd1);
        check({tag, ".mem_we"}, 32'(mem_we), 32'(w));
        check({tag, ".mem_addr"}, 32'(mem_addr), 32'(ea));
        if (w) begin
          check({tag, ".mem_wdata"}, 32'(mem_wdata), (wd >> (8 * i)) & 32'hFF);
          ref_mem[ea] = 8'((wd >> (8 * i)) & 32'hFF);
        end
        check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".early_resp"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
      end
    end else begin
      check({tag, ".err_no_mem"}, 32'(mem_en), 32'd0);
    end
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".resp_err"}, 32'(resp_err), 32'(exp_err));
    check({tag, ".resp_rdata"}, resp_rdata, exp_rd);
    check({tag, ".resp_mem_en"}, 32'(mem_en), 32'd0);
    @(negedge clk);
    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".rdata_hold"}, resp_rdata, exp_rd);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          w;
    logic [2:0]    sz;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic          err;
    logic [31:0]   rd;
    string         name;
  } vec_t;

  vec_t vecs[12];

  initial begin : main
    logic w, e;
    logic [2:0] sz;
    logic [AW-1:0] a;
    logic [31:0] wd, rd;
    int acc[$];
    logic rdy_log[14];
    logic rv_log[14];
    logic [31:0] rd_log[14];

    vecs[0]  = '{1'b1, 3'b010, 17'h00100, 32'hDEADBEEF, 1'b0, 32'h0,        "sw_deadbeef"};
    vecs[1]  = '{1'b0, 3'b010, 17'h00100, 32'h0,        1'b0, 32'hDEADBEEF, "lw_back"};
    vecs[2]  = '{1'b0, 3'b000, 17'h00200, 32'h0,        1'b0, 32'hFFFFFF80, "lb_80"};
    vecs[3]  = '{1'b0, 3'b100, 17'h00200, 32'h0,        1'b0, 32'h00000080, "lbu_80"};
    vecs[4]  = '{1'b0, 3'b001, 17'h00300, 32'h0,        1'b0, 32'hFFFF9234, "lh_9234"};
    vecs[5]  = '{1'b0, 3'b101, 17'h00300, 32'h0,        1'b0, 32'h00009234, "lhu_9234"};
    vecs[6]  = '{1'b0, 3'b011, 17'h00300, 32'h0,        1'b1, 32'h0,        "size_011"};
    vecs[7]  = '{1'b1, 3'b100, 17'h00400, 32'h12345678, 1'b1, 32'h0,        "store_bu"};
    vecs[8]  = '{1'b1, 3'b000, 17'h00400, 32'hCAFE005A, 1'b0, 32'h0,        "sb_5a"};
    vecs[9]  = '{1'b0, 3'b100, 17'h00400, 32'h0,        1'b0, 32'h0000005A, "lbu_5a"};
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    vecs[10] = '{1'b0, 3'b001, 17'h1FFFF, 32'h0,        1'b1, 32'h0,        "lh_wrap"};
    vecs[11] = '{1'b0, 3'b010, 17'h00102, 32'h0,        1'b1, 32'h0,        "lw_misalign"};
`else
    vecs[10] = '{1'b0, 3'b001, 17'h1FFFF, 32'h0,        1'b0, 32'hFFFFF011, "lh_wrap"};
    vecs[11] = '{1'b0, 3'b010, 17'h00102, 32'h0,        1'b0, 32'h0201DEAD, "lw_misalign"};
`endif

    for (int i = 0; i < MEM_BYTES; i++) preload(AW'(i), 8'($urandom));
    preload(17'h00200, 8'h80);
    preload(17'h00300, 8'h34);
    preload(17'h00301, 8'h92);
    preload(17'h1FFFF, 8'h11);
    preload(17'h00000, 8'hF0);
    preload(17'h00104, 8'h01);
    preload(17'h00105, 8'h02);
    for (int i = 0; i < 4; i++) preload(17'h00500 + AW'(i), 8'h00);

    // ---------------- reset values ----------------
    #1;
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.mem_en", 32'(mem_en), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'd0);
    check("rst.dbg_state", 32'(dbg_state), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 12; i++)
      do_txn(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].err, vecs[i].rd, vecs[i].name);

    // ---------------- reset during a store word ----------------
    @(negedge clk);
    req_write = 1'b1; req_size = 3'b010; req_addr = 17'h00500; req_wdata = 32'h11223344;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.req_ready", 32'(req_ready), 32'd1);
    check("midrst.resp_valid", 32'(resp_valid), 32'd0);
    check("midrst.resp_err", 32'(resp_err), 32'd0);
    check("midrst.resp_rdata", resp_rdata, 32'd0);
    check("midrst.mem_en", 32'(mem_en), 32'd0);
    check("midrst.mem_we", 32'(mem_we), 32'd0);
    check("midrst.mem_addr", 32'(mem_addr), 32'd0);
    check("midrst.mem_wdata", 32'(mem_wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("midrst.no_resp", 32'(resp_valid), 32'd0);
      check("midrst.ready_after", 32'(req_ready), 32'd1);
    end
    check("midrst.byte0", 32'(mem[17'h00500]), 32'h44);
    check("midrst.byte1", 32'(mem[17'h00501]), 32'h33);
    check("midrst.byte2", 32'(mem[17'h00502]), 32'h00);
    check("midrst.byte3", 32'(mem[17'h00503]), 32'h00);
    ref_mem[17'h00500] = 8'h44;
    ref_mem[17'h00501] = 8'h33;

    // ---------------- back-to-back word loads with req_valid held ----------------
    req_write = 1'b0; req_size = 3'b010; req_addr = 17'h00100; req_wdata = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0) req_valid = 1'b1;
      if (acc.size() >= 2) req_valid = 1'b0;
      rdy_log[c] = req_ready;
      rv_log[c]  = resp_valid;
      rd_log[c]  = resp_rdata;
      if (req_valid && req_ready) acc.push_back(c);
    end
    req_valid = 1'b0;
    check("b2b.accepts", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      check("b2b.spacing", 32'(acc[1] - acc[0]), 32'd6);
      for (int c = acc[0] + 1; c < acc[0] + 6 && c < 14; c++)
        check("b2b.ready_low", 32'(rdy_log[c]), 32'd0);
      if (acc[0] + 5 < 14) begin
        check("b2b.resp_valid", 32'(rv_log[acc[0] + 5]), 32'd1);
        check("b2b.resp_rdata", rd_log[acc[0] + 5], 32'hDEADBEEF);
      end
    end
    repeat (2) @(negedge clk);

    // ---------------- randomized requests against the model ----------------
    for (int t = 0; t < 80; t++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = 17'h1FFFC + AW'($urandom_range(0, 3));
      else a = AW'($urandom_range(0, MEM_BYTES - 1));
      wd = $urandom;
      e  = model_err(w, sz, a);
      rd = (e || w) ? 32'h0 : model_load(sz, a);
      do_txn(w, sz, a, wd, e, rd, $sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
